// File: rtl/sd_pkg.sv
// Shared SD SPI-mode definitions: response type codes, receiver states and R1 flag bits.
package sd_pkg;

    localparam logic [1:0] RESP_R1  = 2'd0;
    localparam logic [1:0] RESP_R1B = 2'd1;
    localparam logic [1:0] RESP_R7  = 2'd2;

    // R1 flag bit positions
    localparam int IDLE_STATE  = 0;
    localparam int ILLEGAL_CMD = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SB,
        S_R1_BITS,
        S_EXT_BITS,
        S_BUSY_WAIT,
        S_DONE
    } rxState_e;

endpackage

// File: rtl/sd_resp_rx_if.sv
// Sequencer-side handshake and result bus of the SD response receiver.
interface sd_resp_rx_if;
    logic        isStart;
    logic [1:0]  respType;
    logic        isBusy;
    logic        isFinish;
    logic        isTimeout;
    logic [7:0]  r1;
    logic [31:0] payload;

    modport master (output isStart, respType, input isBusy, isFinish, isTimeout, r1, payload);
    modport slave  (input isStart, respType, output isBusy, isFinish, isTimeout, r1, payload);
endinterface

// File: rtl/sd_shift_in.sv
// MSB-first serial-in shift register with synchronous clear.
module sd_shift_in #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= {q[WIDTH-2:0], din};
    end

endmodule

// File: rtl/sd_resp_rx.sv
// SPI-mode SD response receiver: hunts the R1 start bit, captures R1 and an optional
// 32-bit trailer or waits out R1b busy, then reports through a level start/busy/finish handshake.
module sd_resp_rx
    import sd_pkg::*;
#(
    parameter int NCR_MAX  = 80,
    parameter int BUSY_MAX = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        DO,
    sd_resp_rx_if.slave seq
);

    localparam int NCR_W  = (NCR_MAX  > 1) ? $clog2(NCR_MAX)  : 1;
    localparam int BUSY_W = (BUSY_MAX > 1) ? $clog2(BUSY_MAX) : 1;
    localparam logic [NCR_W-1:0]  NCR_LAST  = NCR_W'(NCR_MAX - 1);
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BUSY_MAX - 1);

    rxState_e          state, stateNx;
    logic [1:0]        typeQ;
    logic [NCR_W-1:0]  ncr;
    logic [4:0]        cnt;
    logic [BUSY_W-1:0] bcnt;
    logic              tmoQ, sbMissQ;
    logic              accept, clrSh, r1En, plEn, sbTo, busyTo;
    logic [7:0]        r1Sh;
    logic [31:0]       plSh;

    sd_shift_in #(.WIDTH(8)) u_r1Sh (
        .clk(clk), .rst_n(rst_n), .clr(clrSh), .en(r1En), .din(DO), .q(r1Sh)
    );

    sd_shift_in #(.WIDTH(32)) u_plSh (
        .clk(clk), .rst_n(rst_n), .clr(clrSh), .en(plEn), .din(DO), .q(plSh)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= stateNx;
    end

    always_comb begin
        stateNx = state;
        accept  = 1'b0;
        clrSh   = 1'b0;
        r1En    = 1'b0;
        plEn    = 1'b0;
        sbTo    = 1'b0;
        busyTo  = 1'b0;
        case (state)
            S_IDLE: begin
                if (seq.isStart) begin
                    accept  = 1'b1;
                    clrSh   = 1'b1;
                    stateNx = S_WAIT_SB;
                end
            end
            S_WAIT_SB: begin
                // the start bit itself is r1[7], so it is shifted in here
                if (!DO) begin
                    r1En    = 1'b1;
                    stateNx = S_R1_BITS;
                end else if (ncr == NCR_LAST) begin
                    sbTo    = 1'b1;
                    stateNx = S_DONE;
                end
            end
            S_R1_BITS: begin
                r1En = 1'b1;
                if (cnt == 5'd0) begin
                    if (typeQ == RESP_R7)       stateNx = S_EXT_BITS;
                    else if (typeQ == RESP_R1B) stateNx = S_BUSY_WAIT;
                    else                        stateNx = S_DONE;
                end
            end
            S_EXT_BITS: begin
                plEn = 1'b1;
                if (cnt == 5'd0) stateNx = S_DONE;
            end
            S_BUSY_WAIT: begin
                if (DO) begin
                    stateNx = S_DONE;
                end else if (bcnt == BUSY_LAST) begin
                    busyTo  = 1'b1;
                    stateNx = S_DONE;
                end
            end
            S_DONE: begin
                if (!seq.isStart) stateNx = S_IDLE;
            end
            default: stateNx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            typeQ   <= RESP_R1;
            ncr     <= '0;
            cnt     <= '0;
            bcnt    <= '0;
            tmoQ    <= 1'b0;
            sbMissQ <= 1'b0;
        end else if (accept) begin
            typeQ   <= seq.respType;
            ncr     <= '0;
            cnt     <= '0;
            bcnt    <= '0;
            tmoQ    <= 1'b0;
            sbMissQ <= 1'b0;
        end else begin
            if (state == S_WAIT_SB && DO) ncr <= ncr + 1'b1;

            if (state == S_WAIT_SB && !DO)
                cnt <= 5'd6;
            else if (state == S_R1_BITS && cnt == 5'd0)
                cnt <= 5'd31;
            else if ((state == S_R1_BITS || state == S_EXT_BITS) && cnt != 5'd0)
                cnt <= cnt - 1'b1;

            if (state == S_R1_BITS)                bcnt <= '0;
            else if (state == S_BUSY_WAIT && !DO)  bcnt <= bcnt + 1'b1;

            if (sbTo || busyTo) begin
                tmoQ    <= 1'b1;
                sbMissQ <= sbTo;
            end
        end
    end

    // Outputs are registered one edge behind the state, so the first DONE cycle
    // is the one where isFinish is still low: that is when the results publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq.isBusy    <= 1'b0;
            seq.isFinish  <= 1'b0;
            seq.isTimeout <= 1'b0;
            seq.r1        <= 8'hFF;
            seq.payload   <= '0;
        end else begin
            seq.isFinish <= (state == S_DONE);
            seq.isBusy   <= (state == S_IDLE) ? seq.isStart : 1'b1;
            if (accept) seq.isTimeout <= 1'b0;
            if (state == S_DONE && !seq.isFinish) begin
                seq.isTimeout <= tmoQ;
                seq.r1        <= sbMissQ ? 8'hFF : r1Sh;
                seq.payload   <= (typeQ == RESP_R7) ? plSh : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_sd_resp_rx.sv
// Scoreboard bench for sd_resp_rx: two instances (default BUSY_MAX and BUSY_MAX=16) share stimulus.
module tb_sd_resp_rx;
    import sd_pkg::*;

    typedef struct packed {
        logic [7:0]  r1;
        logic [31:0] pl;
        logic        tmo;
        int          fin;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       DO;
    logic       isStart;
    logic [1:0] respType;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         acc;
    exp_t       qA[$];
    exp_t       qB[$];
    logic       finAd = 1'b0;
    logic       finBd = 1'b0;

    sd_resp_rx_if ifA();
    sd_resp_rx_if ifB();

    assign ifA.isStart  = isStart;
    assign ifA.respType = respType;
    assign ifB.isStart  = isStart;
    assign ifB.respType = respType;

    sd_resp_rx #(.NCR_MAX(80), .BUSY_MAX(65535)) dutA (
        .clk(clk), .rst_n(rst_n), .DO(DO), .seq(ifA)
    );
    sd_resp_rx #(.NCR_MAX(80), .BUSY_MAX(16)) dutB (
        .clk(clk), .rst_n(rst_n), .DO(DO), .seq(ifB)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    function automatic exp_t mk(logic [7:0] r1, logic [31:0] pl, logic tmo, int fin);
        exp_t e;
        e.r1 = r1; e.pl = pl; e.tmo = tmo; e.fin = fin;
        return e;
    endfunction

    function automatic void chkResp(string t, exp_t e, logic [7:0] r1, logic [31:0] pl,
                                    logic tmo, logic busy);
        chk({t, "_r1"}, r1, e.r1);
        chk({t, "_payload"}, pl, e.pl);
        chk({t, "_timeout"}, tmo, e.tmo);
        chk({t, "_busy"}, busy, 1'b1);
        if (e.fin != 0) chk({t, "_latency"}, cyc, e.fin);
    endfunction

    // monitors: compare on each rising isFinish
    always @(negedge clk) begin
        if (ifA.isFinish && !finAd) begin
            if (qA.size() == 0) chk("A_unexpected_finish", 1, 0);
            else chkResp("A", qA.pop_front(), ifA.r1, ifA.payload, ifA.isTimeout, ifA.isBusy);
        end
        finAd <= ifA.isFinish;
    end

    always @(negedge clk) begin
        if (ifB.isFinish && !finBd) begin
            if (qB.size() == 0) chk("B_unexpected_finish", 1, 0);
            else chkResp("B", qB.pop_front(), ifB.r1, ifB.payload, ifB.isTimeout, ifB.isBusy);
        end
        finBd <= ifB.isFinish;
    end

    task automatic req(input logic [1:0] t, output int a);
        @(negedge clk);
        isStart  = 1'b1;
        respType = t;
        @(negedge clk);
        a = cyc;
    endtask

    task automatic drv(input logic [63:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            DO = bits[i];
            @(negedge clk);
        end
        DO = 1'b1;
    endtask

    task automatic waitFin(input int lim);
        int i;
        i = 0;
        while (!(ifA.isFinish && ifB.isFinish) && i < lim) begin
            @(negedge clk);
            i++;
        end
        if (i >= lim) chk("finish_wait_bound", 0, 1);
    endtask

    task automatic dropReq();
        isStart = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no_finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        isStart = 1'b0; respType = RESP_R1; DO = 1'b1; rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", ifA.isBusy, 0);
        chk("rst_finish", ifA.isFinish, 0);
        chk("rst_timeout", ifA.isTimeout, 0);
        chk("rst_r1", ifA.r1, 8'hFF);
        chk("rst_payload", ifA.payload, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // R1 after three idle-high bits
        req(RESP_R1, acc);
        qA.push_back(mk(8'h01, 0, 0, acc + 12));
        qB.push_back(mk(8'h01, 0, 0, acc + 12));
        drv(64'b111_00000001, 11);
        waitFin(200);
        dropReq();

        // DO stuck high: start-bit timeout after NCR_MAX samples
        req(RESP_R1, acc);
        qA.push_back(mk(8'hFF, 0, 1, acc + 81));
        qB.push_back(mk(8'hFF, 0, 1, acc + 81));
        waitFin(200);
        repeat (5) @(negedge clk);
        chk("t3_busy_held", ifA.isBusy, 1);
        chk("t3_finish_held", ifA.isFinish, 1);
        isStart = 1'b0;
        @(negedge clk);
        chk("t3_busy_one_more", ifA.isBusy, 1);
        @(negedge clk);
        chk("t3_busy_drop", ifA.isBusy, 0);
        chk("t3_finish_drop", ifA.isFinish, 0);

        // R1b with 100 busy clocks: A completes, B (BUSY_MAX=16) times out
        req(RESP_R1B, acc);
        qA.push_back(mk(8'h00, 0, 0, acc + 110));
        qB.push_back(mk(8'h00, 0, 1, acc + 25));
        drv(64'h0, 8);
        DO = 1'b0;
        repeat (100) @(negedge clk);
        DO = 1'b1;
        waitFin(300);
        dropReq();

        // R7 (CMD8 echo)
        req(RESP_R7, acc);
        qA.push_back(mk(8'h01, 32'h000001AA, 0, acc + 41));
        qB.push_back(mk(8'h01, 32'h000001AA, 0, acc + 41));
        drv({8'h01, 32'h000001AA}, 40);
        waitFin(100);
        repeat (4) @(negedge clk);
        chk("t2_finish_held_A", ifA.isFinish, 1);
        chk("t2_finish_held_B", ifB.isFinish, 1);
        dropReq();

        // reset in the middle of the trailer
        req(RESP_R7, acc);
        drv(64'h01, 8);
        drv(64'b1011, 4);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", ifA.isBusy, 0);
        chk("t5_finish", ifA.isFinish, 0);
        chk("t5_timeout", ifA.isTimeout, 0);
        chk("t5_r1", ifA.r1, 8'hFF);
        chk("t5_payload", ifA.payload, 0);
        isStart = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req(RESP_R1, acc);
        qA.push_back(mk(8'h05, 0, 0, acc + 9));
        qB.push_back(mk(8'h05, 0, 0, acc + 9));
        drv(64'h05, 8);
        waitFin(50);
        dropReq();

        // isStart dropped during R1 bits: single-cycle finish pulse
        req(RESP_R1, acc);
        qA.push_back(mk(8'h04, 0, 0, acc + 9));
        qB.push_back(mk(8'h04, 0, 0, acc + 9));
        drv(64'b000, 3);
        isStart = 1'b0;
        drv(64'b00100, 5);
        @(negedge clk);
        chk("t6_pulse", ifA.isFinish, 1);
        @(negedge clk);
        chk("t6_pulse_end", ifA.isFinish, 0);
        chk("t6_idle_busy", ifA.isBusy, 0);

        // back-to-back: one low isStart sample leaves DONE, next edge re-accepts
        req(RESP_R1, acc);
        qA.push_back(mk(8'h01, 0, 0, acc + 9));
        qB.push_back(mk(8'h01, 0, 0, acc + 9));
        drv(64'h01, 8);
        waitFin(50);
        isStart = 1'b0;
        @(negedge clk);
        isStart = 1'b1;
        respType = RESP_R1;
        @(negedge clk);
        acc = cyc;
        chk("b2b_busy", ifA.isBusy, 1);
        chk("b2b_finish", ifA.isFinish, 0);
        qA.push_back(mk(8'h7E, 0, 0, acc + 9));
        qB.push_back(mk(8'h7E, 0, 0, acc + 9));
        drv(64'h7E, 8);
        waitFin(50);
        dropReq();

        repeat (5) @(negedge clk);
        chk("queueA_empty", qA.size(), 0);
        chk("queueB_empty", qB.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
